fifo_lifo_buffer: RTL
=====================

# fifo_lifo_buffer

Parametrised, runtime-switchable FIFO/LIFO buffer. It succeeds the fixed 8×8 FIFO/LIFO datapath with several additions:
- configurable width, depth and watermarks;
- an occupancy count;
- simultaneous read/write;
- sticky error flags;
- a drain-before-switch mode change.

It sits between a producer and a consumer in the same single-clock domain.

## Interface
- WIDTH, 8: data bits per entry.
- DEPTH, 8: entries; power of two, ≥ 2.
- AF_LEVEL, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2: `almost_empty` asserts when count ≤ AE_LEVEL.
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- en  in  1  block enable; when low, `wr_en`, `rd_en` and `mode_req` are ignored.
- mode_req  in  2  requested mode: 00 FIFO, 01 LIFO, 1x reserved (ignored).
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- clear  in  1  synchronous flush of contents and error flags.
- din  in  WIDTH  write data.
- dout  out  WIDTH  read data, registered.
- dout_valid  out  1  one-cycle pulse; `dout` is valid.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty, full, almost_empty, almost_full  out  1  status flags, combinational from `count`.
- mode  out  2  active mode.
- draining  out  1  high while a mode switch is pending.
- overflow, underflow  out  1  sticky error flags; cleared by reset or `clear`.

## Operation
- FSM states: S_FIFO, S_LIFO, S_DRAIN.
- Reset:
  - state S_FIFO, `mode` 00;
  - pointers 0, `count` 0;
  - `dout` 0, `dout_valid` 0;
  - `empty` 1; `almost_empty` 1 (since AE_LEVEL ≥ 0);
  - `full`, `almost_full`, `draining`, `overflow`, `underflow` all 0.
- Mode change, when `mode_req` ≠ `mode` and `en` is high:
  - If `count` == 0, `mode` switches on the next edge.
  - Otherwise enter S_DRAIN: `draining` = 1; reads proceed in the old mode; writes are rejected and set `overflow`.
  - On the cycle `count` reaches 0, go to the requested state and clear `draining`.
  - `mode_req` is re-sampled each cycle in S_DRAIN. If it returns to the current mode, drop back without switching.
- FIFO:
  - Write stores at `wptr`, then `wptr++`. Read takes from `rptr`, then `rptr++`.
  - Pointers wrap modulo DEPTH.
- LIFO:
  - `sp` = `count`. A push stores at `sp`. A pop reads `sp`-1.
- Simultaneous `rd_en` and `wr_en`:
  - Non-empty FIFO, including when full: both are performed; `count` is unchanged.
  - Non-empty LIFO: pop returns the old top and the push overwrites the same slot; `count` is unchanged.
  - Empty, either mode: write only; the read is rejected and `underflow` is set. There is no bypass.
- Rejections:
  - A write when full with no read is dropped and sets `overflow`.
  - A read when empty is dropped and sets `underflow`; `dout` holds and `dout_valid` = 0.
- `clear`:
  - Next edge: `count` = 0, pointers = 0, error flags = 0.
  - Mode is kept. S_DRAIN completes to the requested mode.
  - Takes priority over same-cycle reads and writes.
- Arithmetic:
  - Pointers are $clog2(DEPTH) bits, wrapping naturally.
  - `count` saturates in logic only; it never exceeds DEPTH by construction.

## Timing
- Write: data is visible to a read request on the following cycle.
- Read latency is 1: with `rd_en` accepted at edge N, `dout` and `dout_valid` are valid after edge N.
- `dout_valid` is high for exactly one cycle per accepted read; back-to-back reads give one item per cycle.
- `count` and the status flags update on the edge after the accepted operation.
- Priority: `reset` > `clear` > mode logic > read/write.
- Reset asserted mid-operation discards all contents on that edge.

## Structure
- Package `buf_pkg`:
  - mode encoding enum (MODE_FIFO, MODE_LIFO);
  - FSM state enum;
  - a `PTR_W` helper function.
- Sub-module `buf_mem`: DEPTH×WIDTH register array with one synchronous write port and one synchronous read port, so read data is registered inside it.
- Control, pointers, FSM and flags live in the `fifo_lifo_buffer` top.

## Test plan
Every scenario runs with WIDTH=8, DEPTH=8, AF=6, AE=2.
- FIFO fill/drain: write 0x01..0x08 → `full`=1 and `count`=8; a 9th write sets `overflow`. Eight reads return 0x01..0x08, each with `dout_valid`, then `empty`=1.
- LIFO: with `mode_req`=01 while empty, `mode`=01 next cycle. Push 0xA0,0xA1,0xA2; pops return 0xA2,0xA1,0xA0.
- Simultaneous r/w:
  - FIFO holding 0x10,0x11, read+write of 0x12 → `dout`=0x10 and `count` stays 2.
  - Full LIFO, read+write of 0x55 → `dout` = old top, and the next pop returns 0x55.
- Drain switch: FIFO holding 3 entries, `mode_req`=01 → `draining`=1 and writes set `overflow`. Three reads return in FIFO order, then `mode`=01 and `draining`=0.
- Underflow/clear: read when empty → `underflow`=1 and no `dout_valid`. Then `clear` → `count`=0 and `underflow`=0.
- Reset mid-burst: after 4 writes, assert `reset` low for one cycle → `count`=0, `empty`=1, `mode`=00, `dout`=0.

Source files
------------

// File: rtl/buf_pkg.sv
// Shared types and helpers for the runtime-switchable FIFO/LIFO buffer.
package buf_pkg;

    // Active ordering discipline; encoding matches the mode_req/mode ports.
    typedef enum logic [1:0] {
        MODE_FIFO = 2'b00,
        MODE_LIFO = 2'b01
    } mode_t;

    // Controller states; S_DRAIN empties the buffer before a mode change.
    typedef enum logic [1:0] {
        S_FIFO  = 2'd0,
        S_LIFO  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Address width for a given depth (at least one bit).
    function automatic int PTR_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Steady state that serves a given mode.
    function automatic state_t mode_state(input mode_t m);
        return (m == MODE_LIFO) ? S_LIFO : S_FIFO;
    endfunction

endpackage

// File: rtl/buf_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// synchronous read port. The read returns the contents from before a
// same-edge write, which the LIFO pop+push overwrite relies on.
module buf_mem
    import buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = PTR_W(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Next array contents: at most one entry replaced per cycle.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Read register loads only on an accepted read, otherwise holds.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage array carries no reset; occupancy lives in the controller.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read data register clears on reset so dout starts at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_lifo_buffer.sv
// Runtime-switchable FIFO/LIFO buffer: occupancy count, watermark flags,
// simultaneous read/write, sticky error flags and a drain-before-switch
// mode change. Storage lives in buf_mem; control lives here.
module fifo_lifo_buffer
    import buf_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [1:0]             mode_req,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [1:0]             mode,
    output logic                   draining,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = PTR_W(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    // Occupancy update that can never leave 0..DEPTH.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
        logic [CW-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = (cnt == FULL_CNT) ? cnt : cnt + CW'(1);
        end else if (dec && !inc) begin
            res = (cnt == '0) ? cnt : cnt - CW'(1);
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    mode_t            tgt_q, tgt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             dvld_q, dvld_d;

    logic             req_ok;
    mode_t            req_mode;
    logic             switch_now;
    mode_t            acc_mode;
    logic             rd_req, wr_req;
    logic             rd_ok, wr_ok;
    logic [AW-1:0]    sp_m1;
    logic [AW-1:0]    mem_waddr, mem_raddr;

    assign req_mode = mode_req[0] ? MODE_LIFO : MODE_FIFO;

    // Access arbitration, addressing and counter/flag next values. An
    // immediate (empty) mode switch serves this cycle's access in the new mode.
    always_comb begin
        req_ok     = en && !mode_req[1];
        switch_now = !clear && (state_q != S_DRAIN) && req_ok &&
                     (req_mode != mode_q) && (count_q == '0);
        acc_mode   = switch_now ? req_mode : mode_q;

        rd_req = en && rd_en && !clear;
        wr_req = en && wr_en && !clear;
        rd_ok  = rd_req && (count_q != '0);
        wr_ok  = wr_req && (state_q != S_DRAIN) && ((count_q != FULL_CNT) || rd_ok);

        sp_m1 = AW'(count_q - CW'(1));
        if (acc_mode == MODE_LIFO) begin
            mem_raddr = sp_m1;
            mem_waddr = rd_ok ? sp_m1 : AW'(count_q);
        end else begin
            mem_raddr = rptr_q;
            mem_waddr = wptr_q;
        end

        if (clear || (acc_mode == MODE_LIFO)) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wr_ok ? wptr_q + AW'(1) : wptr_q;
            rptr_d = rd_ok ? rptr_q + AW'(1) : rptr_q;
        end

        count_d = clear ? '0 : next_count(count_q, wr_ok, rd_ok);
        ovf_d   = clear ? 1'b0 : (ovf_q || (wr_req && !wr_ok));
        udf_d   = clear ? 1'b0 : (udf_q || (rd_req && !rd_ok));
        dvld_d  = rd_ok;
    end

    // Mode FSM: immediate switch when empty, otherwise drain in the old mode
    // and switch on the edge the buffer empties.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tgt_d   = tgt_q;
        if (clear) begin
            if (state_q == S_DRAIN) begin
                state_d = mode_state(tgt_q);
                mode_d  = tgt_q;
            end
        end else if (state_q == S_DRAIN) begin
            if (req_ok && (req_mode == mode_q)) begin
                state_d = mode_state(mode_q);
            end else begin
                if (req_ok) begin
                    tgt_d = req_mode;
                end
                if (count_d == '0) begin
                    state_d = mode_state(tgt_d);
                    mode_d  = tgt_d;
                end
            end
        end else if (req_ok && (req_mode != mode_q)) begin
            if (count_q == '0) begin
                state_d = mode_state(req_mode);
                mode_d  = req_mode;
            end else begin
                state_d = S_DRAIN;
                tgt_d   = req_mode;
            end
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FIFO;
            mode_q  <= MODE_FIFO;
            tgt_q   <= MODE_FIFO;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tgt_q   <= tgt_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            dvld_q  <= dvld_d;
        end
    end

    buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok),
        .waddr (mem_waddr),
        .wdata (din),
        .re    (rd_ok),
        .raddr (mem_raddr),
        .rdata (dout)
    );

    assign dout_valid   = dvld_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign mode         = mode_q;
    assign draining     = (state_q == S_DRAIN);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
